// File: rtl/pipe_datapath.sv
// Two-stage datapath: ISSUE reads forwarded operands into EX, and EX runs the ALU
// and does the writeback, flags and result update on the next unstalled edge.
module pipe_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic                     stall,
  input  logic                     wen,
  input  logic [$clog2(NREGS)-1:0] selRd,
  input  logic [$clog2(NREGS)-1:0] selRs,
  input  logic [$clog2(NREGS)-1:0] selRt,
  input  logic [3:0]               aluOp,
  input  logic [WIDTH-1:0]         t,
  input  logic                     selT,
  output logic                     fZ,
  output logic                     fC,
  output logic                     fN,
  output logic                     fV,
  output logic [WIDTH-1:0]         rout,
  output logic [WIDTH-1:0]         aout,
  output logic                     aout_valid
);

  localparam int unsigned AW  = $clog2(NREGS);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;

  logic [WIDTH-1:0] regs [NREGS];

  logic             ex_valid;
  logic             ex_wen;
  logic [AW-1:0]    ex_rd;
  logic [3:0]       ex_op;
  logic [WIDTH-1:0] ex_op1;
  logic [WIDTH-1:0] ex_op2;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op1_fwd;
  logic [WIDTH-1:0] op2_fwd;
  logic             fwd;

  // Operand fetch; the EX result bypasses the regfile write that lands on the same edge.
  always_comb begin
    fwd     = ex_valid & ex_wen;
    op1_fwd = (fwd && ex_rd == selRs) ? alu_res : regs[selRs];
    if (selT) begin
      op2_fwd = t;
    end else begin
      op2_fwd = (fwd && ex_rd == selRt) ? alu_res : regs[selRt];
    end
  end

  // ALU; SUB is op1 + ~op2 + 1 so carry out means no borrow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
    case (ex_op)
      OP_ADD: begin
        sum     = {1'b0, ex_op1} + {1'b0, ex_op2};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (ex_op1[MSB] == ex_op2[MSB]) && (alu_res[MSB] != ex_op1[MSB]);
      end
      OP_SUB: begin
        sum     = {1'b0, ex_op1} + {1'b0, ~ex_op2} + (WIDTH+1)'(1);
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (ex_op1[MSB] != ex_op2[MSB]) && (alu_res[MSB] != ex_op1[MSB]);
      end
      OP_AND:  alu_res = ex_op1 & ex_op2;
      OP_OR:   alu_res = ex_op1 | ex_op2;
      OP_XOR:  alu_res = ex_op1 ^ ex_op2;
      OP_NOT:  alu_res = ~ex_op1;
      OP_SHL: begin
        alu_res = {ex_op1[MSB-1:0], 1'b0};
        alu_c   = ex_op1[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, ex_op1[MSB:1]};
        alu_c   = ex_op1[0];
      end
      OP_PASS: alu_res = ex_op2;
      default: alu_res = '0;
    endcase
  end

  // Pipeline, regfile and result registers; a stall freezes everything but aout_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      ex_valid   <= 1'b0;
      ex_wen     <= 1'b0;
      ex_rd      <= '0;
      ex_op      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      aout       <= '0;
      aout_valid <= 1'b0;
      fZ         <= 1'b0;
      fC         <= 1'b0;
      fN         <= 1'b0;
      fV         <= 1'b0;
    end else if (stall) begin
      aout_valid <= 1'b0;
    end else begin
      aout_valid <= ex_valid;
      if (ex_valid) begin
        aout <= alu_res;
        fZ   <= (alu_res == '0);
        fC   <= alu_c;
        fN   <= alu_res[MSB];
        fV   <= alu_v;
        if (ex_wen) begin
          regs[ex_rd] <= alu_res;
        end
      end
      ex_valid <= valid_in;
      ex_wen   <= valid_in & wen;
      ex_rd    <= selRd;
      ex_op    <= aluOp;
      ex_op1   <= valid_in ? op1_fwd : '0;
      ex_op2   <= op2_fwd;
    end
  end

  assign rout = ex_op1;

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath: one task per scenario, hand-computed expectations.
module tb_pipe_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        stall;
  logic        wen;
  logic [3:0]  selRd;
  logic [3:0]  selRs;
  logic [3:0]  selRt;
  logic [3:0]  aluOp;
  logic [15:0] t;
  logic        selT;
  logic        fZ, fC, fN, fV;
  logic [15:0] rout;
  logic [15:0] aout;
  logic        aout_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         NOT_ = 4'd5, SHL = 4'd6, SHR = 4'd7, PASS = 4'd8;

  pipe_datapath #(.WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .wen(wen),
    .selRd(selRd), .selRs(selRs), .selRt(selRt), .aluOp(aluOp), .t(t), .selT(selT),
    .fZ(fZ), .fC(fC), .fN(fN), .fV(fV), .rout(rout), .aout(aout), .aout_valid(aout_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic w, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] op, input logic [15:0] imm,
                      input logic st);
    valid_in = v; wen = w; selRd = rd; selRs = rs; selRt = rt; aluOp = op; t = imm; selT = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, ADD, 16'h0, 1'b0);
  endtask

  // Read a register through ADD Rs + 0 with no writeback.
  task automatic read_reg(input logic [3:0] rs, output logic [15:0] val);
    step(1'b1, 1'b0, 4'd0, rs, 4'd0, ADD, 16'h0, 1'b1);
    idle();
    val = aout;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    idle(); idle();
    rst = 1'b0;
    checks++; if (aout !== 16'h0) begin errors++; $display("FAIL reset_aout got %h exp %h", aout, 16'h0); end
    checks++; if (aout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", aout_valid); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {fZ, fC, fN, fV}); end
    checks++; if (rout !== 16'h0) begin errors++; $display("FAIL reset_rout got %h exp 0000", rout); end
  endtask

  task automatic test_pass();
    step(1'b1, 1'b1, 4'd1, 4'd0, 4'd0, PASS, 16'h0005, 1'b1);
    idle();
    checks++; if (aout !== 16'h0005) begin errors++; $display("FAIL pass_aout got %h exp 0005", aout); end
    checks++; if (aout_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b exp 1", aout_valid); end
    checks++; if ({fZ, fN} !== 2'b00) begin errors++; $display("FAIL pass_zn got %b exp 00", {fZ, fN}); end
    idle();
    checks++; if (aout_valid !== 1'b0 || aout !== 16'h0005) begin
      errors++; $display("FAIL bubble_hold got valid=%b aout=%h exp valid=0 aout=0005", aout_valid, aout);
    end
  endtask

  task automatic test_add_forward();
    logic [15:0] r;
    step(1'b1, 1'b1, 4'd1, 4'd0, 4'd0, PASS, 16'h7FFF, 1'b1);
    step(1'b1, 1'b1, 4'd2, 4'd1, 4'd1, ADD, 16'h0, 1'b0);
    checks++; if (aout !== 16'h7FFF) begin errors++; $display("FAIL setup_r1 got %h exp 7fff", aout); end
    step(1'b1, 1'b1, 4'd3, 4'd2, 4'd1, ADD, 16'h0, 1'b0);
    checks++; if (aout !== 16'hFFFE) begin errors++; $display("FAIL add1_aout got %h exp fffe", aout); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b0011) begin errors++; $display("FAIL add1_flags got %b exp 0011", {fZ, fC, fN, fV}); end
    checks++; if (rout !== 16'hFFFE) begin errors++; $display("FAIL add2_rout got %h exp fffe", rout); end
    idle();
    checks++; if (aout !== 16'h7FFD) begin errors++; $display("FAIL add2_aout got %h exp 7ffd", aout); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b0100) begin errors++; $display("FAIL add2_flags got %b exp 0100", {fZ, fC, fN, fV}); end
    read_reg(4'd3, r);
    checks++; if (r !== 16'h7FFD) begin errors++; $display("FAIL r3_written got %h exp 7ffd", r); end
  endtask

  task automatic test_sub();
    step(1'b1, 1'b1, 4'd4, 4'd1, 4'd1, SUB, 16'h0, 1'b0);
    idle();
    checks++; if (aout !== 16'h0) begin errors++; $display("FAIL sub_aout got %h exp 0000", aout); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b1100) begin errors++; $display("FAIL sub_flags got %b exp 1100", {fZ, fC, fN, fV}); end
  endtask

  task automatic test_shift();
    step(1'b1, 1'b1, 4'd6, 4'd0, 4'd0, PASS, 16'h0001, 1'b1);
    step(1'b1, 1'b1, 4'd7, 4'd6, 4'd0, SHR, 16'h0, 1'b0);
    idle();
    checks++; if (aout !== 16'h0) begin errors++; $display("FAIL shr_aout got %h exp 0000", aout); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b1100) begin errors++; $display("FAIL shr_flags got %b exp 1100", {fZ, fC, fN, fV}); end
    step(1'b1, 1'b1, 4'd6, 4'd0, 4'd0, PASS, 16'h8000, 1'b1);
    step(1'b1, 1'b1, 4'd7, 4'd6, 4'd0, SHL, 16'h0, 1'b0);
    idle();
    checks++; if (aout !== 16'h0) begin errors++; $display("FAIL shl_aout got %h exp 0000", aout); end
    checks++; if ({fZ, fC, fN, fV} !== 4'b1100) begin errors++; $display("FAIL shl_flags got %b exp 1100", {fZ, fC, fN, fV}); end
  endtask

  // R1 = 0x7FFF throughout; flags are {Z,C,N,V}.
  task automatic test_logic_ops();
    logic [3:0]  ops   [7] = '{AND_, OR_, XOR_, NOT_, 4'd9, SUB, SUB};
    logic [15:0] imms  [7] = '{16'h00F0, 16'h8000, 16'hFFFF, 16'h0, 16'h1234, 16'h0001, 16'hFFFF};
    logic [15:0] exps  [7] = '{16'h00F0, 16'hFFFF, 16'h8000, 16'h8000, 16'h0, 16'h7FFE, 16'h8000};
    logic [3:0]  flags [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0100, 4'b0011};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 4'd0, 4'd1, 4'd0, ops[i], imms[i], 1'b1);
      idle();
      checks++; if (aout !== exps[i] || {fZ, fC, fN, fV} !== flags[i]) begin
        errors++;
        $display("FAIL alu_op%0d got aout=%h flags=%b exp aout=%h flags=%b",
                 ops[i], aout, {fZ, fC, fN, fV}, exps[i], flags[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] r;
    read_reg(4'd1, r);
    checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL stall_pre_r1 got %h exp 7fff", r); end
    step(1'b1, 1'b1, 4'd8, 4'd1, 4'd1, ADD, 16'h0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd10, 4'd0, 4'd0, PASS, 16'hDEAD, 1'b1);
      checks++; if (aout_valid !== 1'b0 || aout !== 16'h7FFF || rout !== 16'h7FFF) begin
        errors++;
        $display("FAIL stall_cycle%0d got valid=%b aout=%h rout=%h exp valid=0 aout=7fff rout=7fff",
                 i, aout_valid, aout, rout);
      end
    end
    stall = 1'b0;
    step(1'b1, 1'b1, 4'd9, 4'd8, 4'd1, ADD, 16'h0, 1'b0);
    checks++; if (aout_valid !== 1'b1 || aout !== 16'hFFFE || {fZ, fC, fN, fV} !== 4'b0011) begin
      errors++;
      $display("FAIL stall_add1 got valid=%b aout=%h flags=%b exp valid=1 aout=fffe flags=0011",
               aout_valid, aout, {fZ, fC, fN, fV});
    end
    idle();
    checks++; if (aout !== 16'h7FFD || {fZ, fC, fN, fV} !== 4'b0100) begin
      errors++; $display("FAIL stall_add2 got aout=%h flags=%b exp aout=7ffd flags=0100", aout, {fZ, fC, fN, fV});
    end
    read_reg(4'd10, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL stall_no_write got %h exp 0000", r); end
    read_reg(4'd9, r);
    checks++; if (r !== 16'h7FFD) begin errors++; $display("FAIL stall_r9 got %h exp 7ffd", r); end
  endtask

  task automatic test_reset_inflight();
    logic [15:0] r;
    step(1'b1, 1'b1, 4'd5, 4'd0, 4'd0, PASS, 16'h1234, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 4'd5, 4'd0, 4'd0, PASS, 16'h5678, 1'b1);
    rst = 1'b0;
    checks++; if (aout !== 16'h0 || aout_valid !== 1'b0 || {fZ, fC, fN, fV} !== 4'b0000 || rout !== 16'h0) begin
      errors++;
      $display("FAIL rst_inflight_outs got aout=%h valid=%b flags=%b rout=%h exp all 0",
               aout, aout_valid, {fZ, fC, fN, fV}, rout);
    end
    read_reg(4'd5, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL rst_inflight_r5 got %h exp 0000", r); end
    read_reg(4'd1, r);
    checks++; if (r !== 16'h0) begin errors++; $display("FAIL rst_clears_r1 got %h exp 0000", r); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    valid_in = 1'b0; wen = 1'b0; selRd = '0; selRs = '0; selRt = '0;
    aluOp = '0; t = '0; selT = 1'b0;
    test_reset();
    test_pass();
    test_add_forward();
    test_sub();
    test_shift();
    test_logic_ops();
    test_stall();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the data width of the registers, ALU and immediate.
REQ-002 SHALL have parameter NREGS, default 16 (power of two, >=2), meaning the register count; AW = log2(NREGS) is the width of the select fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have ports valid_in (input, 1, issue op this cycle) and stall (input, 1, freeze the pipeline).
REQ-006 SHALL have port wen, input, 1, meaning the issued op writes its result to selRd.
REQ-007 SHALL have ports selRd, selRs and selRt, each input, AW, meaning destination, first operand and second operand.
REQ-008 SHALL have port aluOp, input, 4, meaning the ALU function.
REQ-009 SHALL have ports t (input, WIDTH, immediate) and selT (input, 1; 1 selects t as op2, 0 selects Rt).
REQ-010 SHALL have ports fZ, fC, fN and fV, each output, 1, registered zero/carry/negative/overflow flags.
REQ-011 SHALL have port rout, output, WIDTH, the op1 value held in the EX stage.
REQ-012 SHALL have ports aout (output, WIDTH, registered ALU result) and aout_valid (output, 1).

Function
REQ-013 SHALL be a 2-stage pipeline: ISSUE (operand read, sampled at edge E0) then EX (ALU, writeback, flags, aout at edge E1 = E0+1).
REQ-014 SHALL reflect an op issued with valid_in=1 at edge E0 in aout/aout_valid/flags after E1 (1-cycle latency, throughput 1 op/cycle).
REQ-015 SHALL read operands as op1=R[selRs] and op2 = selT ? t : R[selRt], with forwarding applied.
REQ-016 SHALL forward: if the EX op has wen=1 and its Rd equals selRs or selRt (when selT=0), the ALU result replaces the register value.
REQ-017 SHALL write the regfile at E1 when the EX op is valid with wen=1, so an op issued at E1 or later reads the new value.
REQ-018 SHALL implement ALU ops: 0 ADD, 1 SUB (op1-op2), 2 AND, 3 OR, 4 XOR, 5 NOT op1, 6 SHL op1 by 1, 7 SHR op1 logical by 1, 8 PASS op2; 9-15 result 0.
REQ-019 SHALL truncate arithmetic to WIDTH bits.
REQ-020 SHALL set C on ADD to the carry out, and on SUB to the carry out of op1+~op2+1 (1 = no borrow).
REQ-021 SHALL set C on SHL to the bit shifted out of the MSB and on SHR to the bit shifted out of the LSB; for all other ops C=0.
REQ-022 SHALL set V to signed overflow on ADD/SUB and V=0 otherwise.
REQ-023 SHALL set Z to (result==0) and N to result[WIDTH-1].
REQ-024 SHALL update flags only at the completion of a valid EX op; bubbles hold flags.
REQ-025 SHALL hold aout and the flags when the EX stage carries a bubble, with aout_valid=0 for that cycle.
REQ-026 SHALL, on stall=1, sample nothing, leave both stages and the regfile unchanged, drive aout_valid=0 and ignore valid_in.
REQ-027 SHALL not drop the EX op because of a stall; it completes on the first non-stalled edge.
REQ-028 SHALL make rout equal to the (forwarded) op1 of the op currently in EX, and 0 when EX holds a bubble.
REQ-029 SHALL ignore wen when valid_in=0.

Reset
REQ-030 SHALL, with rst=1 at an edge, clear all registers, both pipeline stages, aout, aout_valid and all flags to 0.
REQ-031 SHALL give rst priority over stall and valid_in, discarding an in-flight op without writeback.

Verification
REQ-032 SHALL be checked with: reset, then PASS t=0x0005 to R1 -> next cycle aout=0x0005, aout_valid=1, Z=0, N=0.
REQ-033 SHALL be checked with: R1=0x7FFF, back-to-back ADD R2=R1+R1 then ADD R3=R2+R1 -> 0xFFFE (V=1, N=1, C=0), then 0x7FFD (C=1, V=0).
REQ-034 SHALL be checked with: SUB R4=R1-R1 -> aout=0, Z=1, C=1.
REQ-035 SHALL be checked with: SHR on 0x0001 -> aout=0, C=1, Z=1; SHL on 0x8000 -> aout=0, C=1.
REQ-036 SHALL be checked with: stall asserted for 3 cycles during back-to-back ops -> no writes, aout_valid=0 throughout, and the results are identical to the unstalled run.
REQ-037 SHALL be checked with: rst asserted while an op to R5 is in EX -> R5 reads 0 and all outputs are 0.
